exec_branch_unit: RTL and testbench
===================================

# exec_branch_unit

Execute-stage arithmetic and branch block of the 8-bit pipelined MCU. It combines the ALU, the branch-target adder and the branch-detection/squash logic, all combinational. It registers the ALU result and flags into the EX/WB pipeline register. It sits between the decode pipeline register and the write-back mux, and drives next-PC selection for the fetch stage.

## Interface
Parameters:
- DW, 8, datapath width
- IW, 17, instruction width
- NOP, 17'h00000, instruction injected on squash

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  pipeline advance; 0 = stall (hold registers)
- fs  in  4  ALU function select
- sh  in  3  shift amount
- a  in  8  bus A operand (also jump-register target)
- b  in  8  bus B operand (also branch offset)
- pc  in  8  PC+1 of the instruction in EX
- pc_inc  in  8  fetch-stage PC+1
- bs  in  2  branch select
- ps  in  1  branch polarity
- rw_in, mw_in  in  1 each  decoded register/memory write enables
- inst_in  in  17  instruction from program memory
- alu_f  out  8  combinational ALU result
- zero, neg, carry, ovf  out  1 each  combinational flags
- bra  out  8  branch target
- next_pc  out  8  selected next PC
- inst_out  out  17  instruction to the IF register
- squash_n  out  1  0 when a branch is in decode
- rw_out, mw_out  out  1 each  enables gated by squash_n
- alu_q  out  8  registered ALU result
- flags_q  out  4  registered {ovf,carry,neg,zero}

## Operation
ALU (8-bit, results taken mod 256; carry is bit 8 of the 9-bit sum):
- 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+1; 0100 A+~B; 0101 A−B (A+~B+1); 0110 A−1; 0111 A.
- 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A; 1100 B; 1101 B>>sh (logical); 1110 B<<sh; 1111 ~B.
- zero = (alu_f==0). neg = alu_f[7].
- carry and ovf are valid for codes 0001–0110 only and are 0 for all other codes.
- ovf is set when both operands as effectively added (A, and B/~B/constant) have the same sign and the result sign differs.

Branch select: bra = pc + b (mod 256).

Branch detection:
- squash_n = ~(bs[1]|bs[0]).
- inst_out = squash_n ? inst_in : NOP.
- rw_out = rw_in & squash_n; mw_out = mw_in & squash_n.

next_pc:
- bs=00: pc_inc.
- bs=01: conditional branch. Taken when (ps ? zero : ~zero); taken → bra, otherwise pc_inc.
- bs=10: a (jump register).
- bs=11: bra (unconditional).

## Timing
- alu_f, flags, bra, next_pc, inst_out, squash_n, rw_out, mw_out: combinational, 0-cycle latency.
- alu_q and flags_q load on the rising clk edge when en=1 and hold when en=0.
- Registered outputs have 1-cycle latency.
- reset low clears alu_q=0 and flags_q=0 immediately (asynchronous), overriding en.
- Release of reset is synchronous to the next clk edge.
- Combinational outputs do not depend on reset.
- Squash and stall at the same time: combinational squash outputs remain valid, and the registers hold.

## Structure
- Shared package mcu_pkg holds:
  - FS opcode localparams (FS_TSA … FS_NOTB)
  - BS encodings (BS_NONE, BS_COND, BS_JMR, BS_JMP)
  - the NOP constant
- One natural sub-module, alu8: purely combinational ALU with flags.
- Adder, detection, next-PC mux and EX/WB register live in the top module.

## Test plan
- Reset: hold reset=0, apply fs=0010, a=8'h05, b=8'h03, clk running. Then: alu_q=0, flags_q=0. Release reset with en=1; one edge later, alu_q=8'h08.
- Arithmetic flags:
  - a=8'h7F, b=8'h01, fs=0010 → alu_f=8'h80, neg=1, ovf=1, carry=0.
  - a=8'hFF, b=8'h01 → alu_f=0, zero=1, carry=1.
  - fs=0101, a=8'h03, b=8'h05 → alu_f=8'hFE, neg=1, carry=0.
- Shifts/logic:
  - b=8'h81, sh=3, fs=1101 → 8'h10.
  - fs=1110 → 8'h08.
  - fs=1010, a=8'hF0, b=8'hFF → 8'h0F.
- Conditional branch: bs=01, pc=8'h10, b=8'hFE, fs=0101, a=b=8'h22. Then zero=1; ps=1 → next_pc=8'h0E; ps=0 → next_pc=pc_inc.
- Squash: bs=11, inst_in=17'h1ABCD, rw_in=mw_in=1 → inst_out=NOP, squash_n=0, rw_out=mw_out=0, next_pc=bra. With bs=00 → inst_out=17'h1ABCD, and rw_out/mw_out pass through.
- Stall: load alu_q=8'h08, then en=0 with new operands for 3 cycles → alu_q stays 8'h08. Asserting reset mid-stall clears it to 0.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared encodings for the 8-bit MCU pipeline.
// Covers ALU function selects, branch selects and the squash instruction.
package mcu_pkg;
   localparam logic [3:0] FS_TSA   = 4'b0000;
   localparam logic [3:0] FS_INC   = 4'b0001;
   localparam logic [3:0] FS_ADD   = 4'b0010;
   localparam logic [3:0] FS_ADDC  = 4'b0011;
   localparam logic [3:0] FS_ADDNB = 4'b0100;
   localparam logic [3:0] FS_SUB   = 4'b0101;
   localparam logic [3:0] FS_DEC   = 4'b0110;
   localparam logic [3:0] FS_TSA2  = 4'b0111;
   localparam logic [3:0] FS_AND   = 4'b1000;
   localparam logic [3:0] FS_OR    = 4'b1001;
   localparam logic [3:0] FS_XOR   = 4'b1010;
   localparam logic [3:0] FS_NOTA  = 4'b1011;
   localparam logic [3:0] FS_TSB   = 4'b1100;
   localparam logic [3:0] FS_SHR   = 4'b1101;
   localparam logic [3:0] FS_SHL   = 4'b1110;
   localparam logic [3:0] FS_NOTB  = 4'b1111;

   localparam logic [1:0] BS_NONE = 2'b00;
   localparam logic [1:0] BS_COND = 2'b01;
   localparam logic [1:0] BS_JMR  = 2'b10;
   localparam logic [1:0] BS_JMP  = 2'b11;

   localparam logic [16:0] NOP_INST = 17'h00000;
endpackage

// File: rtl/alu8.sv
// Combinational ALU with zero/neg/carry/ovf flags.
// Arithmetic codes share one adder: A + operand + carry-in.
module alu8
   import mcu_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic [3:0]    fs,
   input  logic [2:0]    sh,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] f,
   output logic          zero,
   output logic          neg,
   output logic          carry,
   output logic          ovf
);
   logic [DW-1:0] y;
   logic          cin;
   logic          arith;
   logic [DW:0]   sum;

   always_comb begin
      y     = '0;
      cin   = 1'b0;
      arith = 1'b0;
      case (fs)
         FS_INC:   begin y = DW'(1); arith = 1'b1; end
         FS_ADD:   begin y = b;      arith = 1'b1; end
         FS_ADDC:  begin y = b;      cin = 1'b1; arith = 1'b1; end
         FS_ADDNB: begin y = ~b;     arith = 1'b1; end
         FS_SUB:   begin y = ~b;     cin = 1'b1; arith = 1'b1; end
         FS_DEC:   begin y = '1;     arith = 1'b1; end
         default:  ;
      endcase
   end

   assign sum = {1'b0, a} + {1'b0, y} + (DW+1)'(cin);

   always_comb begin
      f = a;
      case (fs)
         FS_AND:  f = a & b;
         FS_OR:   f = a | b;
         FS_XOR:  f = a ^ b;
         FS_NOTA: f = ~a;
         FS_TSB:  f = b;
         FS_SHR:  f = b >> sh;
         FS_SHL:  f = b << sh;
         FS_NOTB: f = ~b;
         default: if (arith) f = sum[DW-1:0];
      endcase
   end

   assign zero  = (f == '0);
   assign neg   = f[DW-1];
   assign carry = arith & sum[DW];
   // Signed overflow: like-signed addends producing an opposite-signed result.
   assign ovf   = arith & (a[DW-1] == y[DW-1]) & (sum[DW-1] != a[DW-1]);
endmodule

// File: rtl/exec_branch_unit.sv
// Execute stage: ALU, branch-target adder, branch detect/squash, next-PC mux
// and the EX/WB register for the ALU result and flags.
module exec_branch_unit
   import mcu_pkg::*;
#(
   parameter int             DW  = 8,
   parameter int             IW  = 17,
   parameter logic [IW-1:0]  NOP = NOP_INST
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [3:0]    fs,
   input  logic [2:0]    sh,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] pc,
   input  logic [DW-1:0] pc_inc,
   input  logic [1:0]    bs,
   input  logic          ps,
   input  logic          rw_in,
   input  logic          mw_in,
   input  logic [IW-1:0] inst_in,
   output logic [DW-1:0] alu_f,
   output logic          zero,
   output logic          neg,
   output logic          carry,
   output logic          ovf,
   output logic [DW-1:0] bra,
   output logic [DW-1:0] next_pc,
   output logic [IW-1:0] inst_out,
   output logic          squash_n,
   output logic          rw_out,
   output logic          mw_out,
   output logic [DW-1:0] alu_q,
   output logic [3:0]    flags_q
);
   alu8 #(.DW(DW)) u_alu (
      .fs(fs), .sh(sh), .a(a), .b(b),
      .f(alu_f), .zero(zero), .neg(neg), .carry(carry), .ovf(ovf)
   );

   assign bra      = pc + b;
   assign squash_n = ~(bs[1] | bs[0]);
   assign inst_out = squash_n ? inst_in : NOP;
   assign rw_out   = rw_in & squash_n;
   assign mw_out   = mw_in & squash_n;

   always_comb begin
      next_pc = pc_inc;
      case (bs)
         BS_COND: if (ps ? zero : ~zero) next_pc = bra;
         BS_JMR:  next_pc = a;
         BS_JMP:  next_pc = bra;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_q   <= '0;
         flags_q <= '0;
      end else if (en) begin
         alu_q   <= alu_f;
         flags_q <= {ovf, carry, neg, zero};
      end
   end
endmodule

// File: tb/tb_exec_branch_unit.sv
// Directed plus randomized checks of exec_branch_unit against an arithmetic model.
module tb_exec_branch_unit;
   logic        clk = 1'b0;
   logic        reset, en, ps, rw_in, mw_in;
   logic [3:0]  fs;
   logic [2:0]  sh;
   logic [7:0]  a, b, pc, pc_inc;
   logic [1:0]  bs;
   logic [16:0] inst_in;
   logic [7:0]  alu_f, bra, next_pc, alu_q;
   logic        zero, neg, carry, ovf, squash_n, rw_out, mw_out;
   logic [16:0] inst_out;
   logic [3:0]  flags_q;

   int checks = 0;
   int errors = 0;

   exec_branch_unit dut (
      .clk(clk), .reset(reset), .en(en), .fs(fs), .sh(sh), .a(a), .b(b),
      .pc(pc), .pc_inc(pc_inc), .bs(bs), .ps(ps), .rw_in(rw_in), .mw_in(mw_in),
      .inst_in(inst_in), .alu_f(alu_f), .zero(zero), .neg(neg), .carry(carry),
      .ovf(ovf), .bra(bra), .next_pc(next_pc), .inst_out(inst_out),
      .squash_n(squash_n), .rw_out(rw_out), .mw_out(mw_out), .alu_q(alu_q),
      .flags_q(flags_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Signed/unsigned addition with integers; returns {v, c, sum[7:0]}.
   function automatic logic [9:0] add(input int x, input int y, input int cin);
      int u, s, sx, sy;
      u  = x + y + cin;
      sx = (x > 127) ? x - 256 : x;
      sy = (y > 127) ? y - 256 : y;
      s  = sx + sy + cin;
      return {((s > 127) || (s < -128)) ? 1'b1 : 1'b0, (u > 255) ? 1'b1 : 1'b0, 8'(u % 256)};
   endfunction

   // Returns {ovf, carry, neg, zero, f[7:0]}.
   function automatic logic [11:0] model(input logic [3:0] f_s, input logic [2:0] s_h,
                                         input logic [7:0] x, input logic [7:0] y);
      logic [9:0] r;
      logic [7:0] f;
      int xi, yi;
      xi = int'(x); yi = int'(y);
      r = 10'd0;
      f = 8'd0;
      case (f_s)
         4'd1:  r = add(xi, 1, 0);
         4'd2:  r = add(xi, yi, 0);
         4'd3:  r = add(xi, yi, 1);
         4'd4:  r = add(xi, 255 - yi, 0);
         4'd5:  r = add(xi, 255 - yi, 1);
         4'd6:  r = add(xi, 255, 0);
         4'd8:  f = x & y;
         4'd9:  f = x | y;
         4'd10: f = x ^ y;
         4'd11: f = 8'(255 - xi);
         4'd12: f = y;
         4'd13: f = 8'(yi / (1 << s_h));
         4'd14: f = 8'((yi * (1 << s_h)) % 256);
         4'd15: f = 8'(255 - yi);
         default: f = x;
      endcase
      if (f_s >= 4'd1 && f_s <= 4'd6) f = r[7:0];
      return {r[9], r[8], f[7], (f == 8'd0), f};
   endfunction

   function automatic logic [7:0] npc_model(input logic [1:0] s, input logic p, input logic z,
                                             input logic [7:0] x, input logic [7:0] y,
                                             input logic [7:0] p1, input logic [7:0] pci);
      logic [7:0] tgt;
      tgt = 8'((int'(p1) + int'(y)) % 256);
      if (s == 2'd0) return pci;
      if (s == 2'd2) return x;
      if (s == 2'd3) return tgt;
      return ((p && z) || (!p && !z)) ? tgt : pci;
   endfunction

   task automatic check_comb(input string tag);
      logic [11:0] m;
      logic        sq;
      m  = model(fs, sh, a, b);
      sq = (bs == 2'd0);
      chk({tag, ".alu_f"}, 32'(alu_f), 32'(m[7:0]));
      chk({tag, ".flags"}, 32'({ovf, carry, neg, zero}), 32'(m[11:8]));
      chk({tag, ".bra"}, 32'(bra), 32'((int'(pc) + int'(b)) % 256));
      chk({tag, ".next_pc"}, 32'(next_pc), 32'(npc_model(bs, ps, m[8], a, b, pc, pc_inc)));
      chk({tag, ".inst_out"}, 32'(inst_out), sq ? 32'(inst_in) : 32'd0);
      chk({tag, ".squash"}, 32'({squash_n, rw_out, mw_out}), 32'({sq, rw_in & sq, mw_in & sq}));
   endtask

   initial begin
      logic [11:0] m;
      logic [7:0]  exp_q;
      logic [3:0]  exp_fl;

      reset = 1'b0; en = 1'b1; fs = 4'b0010; sh = 3'd0; a = 8'h05; b = 8'h03;
      pc = 8'h00; pc_inc = 8'h01; bs = 2'b00; ps = 1'b0; rw_in = 1'b0; mw_in = 1'b0;
      inst_in = 17'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.alu_q", 32'(alu_q), 32'h0);
      chk("reset.flags_q", 32'(flags_q), 32'h0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("release.alu_q", 32'(alu_q), 32'h08);
      chk("release.flags_q", 32'(flags_q), 32'h0);

      // Directed arithmetic / logic cases
      a = 8'h7F; b = 8'h01; fs = 4'b0010; #1;
      chk("ovf.alu_f", 32'(alu_f), 32'h80);
      chk("ovf.nvc", 32'({neg, ovf, carry}), 32'b110);
      check_comb("ovf");
      a = 8'hFF; #1;
      chk("wrap.zc", 32'({alu_f, zero, carry}), 32'({8'h00, 2'b11}));
      fs = 4'b0101; a = 8'h03; b = 8'h05; #1;
      chk("sub.f", 32'({alu_f, neg, carry}), 32'({8'hFE, 2'b10}));
      b = 8'h81; sh = 3'd3; fs = 4'b1101; #1;
      chk("shr", 32'(alu_f), 32'h10);
      fs = 4'b1110; #1;
      chk("shl", 32'(alu_f), 32'h08);
      fs = 4'b1010; a = 8'hF0; b = 8'hFF; #1;
      chk("xor", 32'(alu_f), 32'h0F);

      // Conditional branch on equality
      bs = 2'b01; pc = 8'h10; pc_inc = 8'h33; fs = 4'b0101; a = 8'hFE; b = 8'hFE; ps = 1'b1; #1;
      chk("bcond.zero", 32'(zero), 32'h1);
      chk("bcond.taken", 32'(next_pc), 32'h0E);
      ps = 1'b0; #1;
      chk("bcond.nottaken", 32'(next_pc), 32'h33);

      // Squash
      bs = 2'b11; inst_in = 17'h1ABCD; rw_in = 1'b1; mw_in = 1'b1; #1;
      chk("squash.inst", 32'(inst_out), 32'h0);
      chk("squash.ctl", 32'({squash_n, rw_out, mw_out}), 32'b000);
      chk("squash.npc", 32'(next_pc), 32'h0E);
      bs = 2'b00; #1;
      chk("pass.inst", 32'(inst_out), 32'h1ABCD);
      chk("pass.ctl", 32'({squash_n, rw_out, mw_out}), 32'b111);

      // Stall holds, reset overrides
      @(posedge clk); #1;
      fs = 4'b0010; a = 8'h05; b = 8'h03; en = 1'b1;
      @(posedge clk); #1;
      chk("stall.load", 32'(alu_q), 32'h08);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = 8'($urandom); b = 8'($urandom); fs = 4'($urandom);
         @(posedge clk); #1;
         chk("stall.hold", 32'(alu_q), 32'h08);
      end
      #2 reset = 1'b0; #1;
      chk("stall.reset", 32'({alu_q, flags_q}), 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      exp_q = 8'h00; exp_fl = 4'h0;

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         fs = 4'($urandom); sh = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
         if ($urandom_range(0, 3) == 0) b = a;
         pc = 8'($urandom); pc_inc = 8'($urandom); bs = 2'($urandom); ps = 1'($urandom);
         rw_in = 1'($urandom); mw_in = 1'($urandom); inst_in = 17'($urandom);
         en = ($urandom_range(0, 3) != 0);
         #1;
         check_comb("rand");
         m = model(fs, sh, a, b);
         if (en) begin exp_q = m[7:0]; exp_fl = m[11:8]; end
         @(posedge clk); #1;
         chk("rand.alu_q", 32'(alu_q), 32'(exp_q));
         chk("rand.flags_q", 32'(flags_q), 32'(exp_fl));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
